multi_ch_timing_gen: RTL

- Parametrised NUM_CH-channel successor of the single-channel level-select timing generator.
- Each channel produces one level-select output, timed from the VSYNC rising edge with start/delay/width/period/end parameters.
- Settings are written through an addressed staging-register port, committed per channel, and applied atomically at the next frame start.
- Sits between the control register bank and the level/mux drivers. Adds single-shot mode, per-channel enable and pending status.

---
 rtl/multi_ch_timing_gen_if.sv | 34 +++
 rtl/multi_ch_timing_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/multi_ch_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_ch_timing_gen_if
// Brief    : Staging/commit bus and level outputs of the multi-channel
//            timing generator.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_ch_timing_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 2
);
    logic              WR_EN;
    logic [CH_W-1:0]   WR_CH;
    logic [2:0]        WR_ADDR;
    logic [CNT_W-1:0]  WR_DATA;
    logic              COMMIT;
    logic [NUM_CH-1:0] COMMIT_MASK;
    logic              VSYNC;
    logic [NUM_CH-1:0] PENDING;
    logic [NUM_CH-1:0] SETTING_DONE;
    logic [NUM_CH-1:0] LEVEL_SEL;

    modport master (
        output WR_EN, WR_CH, WR_ADDR, WR_DATA, COMMIT, COMMIT_MASK, VSYNC,
        input  PENDING, SETTING_DONE, LEVEL_SEL
    );

    modport slave (
        input  WR_EN, WR_CH, WR_ADDR, WR_DATA, COMMIT, COMMIT_MASK, VSYNC,
        output PENDING, SETTING_DONE, LEVEL_SEL
    );
endinterface
`default_nettype wire

// File: rtl/multi_ch_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : multi_ch_timing_gen
// Brief    : NUM_CH level-select timing generators referenced to VSYNC, with
//            staged settings applied atomically at frame start.
// Revision : 1.0 - initial release
// ============================================================================
module multi_ch_timing_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 2
) (
    input  wire logic              REF_CLK,
    input  wire logic              nRESET,
    multi_ch_timing_gen_if.slave   bus
);
    localparam int c_F_START  = 0;
    localparam int c_F_DELAY  = 1;
    localparam int c_F_WIDTH  = 2;
    localparam int c_F_PERIOD = 3;
    localparam int c_F_END    = 4;
    localparam int c_F_CTRL   = 5;
    localparam int c_NFIELD   = 5;
    localparam logic [CNT_W-1:0] c_ZERO = '0;
    localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_MAX  = '1;

    logic [CNT_W-1:0]  r_stg      [NUM_CH][c_NFIELD];
    logic [1:0]        r_stg_ctrl [NUM_CH];
    logic [CNT_W-1:0]  r_act      [NUM_CH][c_NFIELD];
    logic [1:0]        r_act_ctrl [NUM_CH];
    logic [CNT_W-1:0]  r_pcnt     [NUM_CH];
    logic [CNT_W-1:0]  r_fcnt;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_done;
    logic [NUM_CH-1:0] r_level;
    logic              r_vs_s1;
    logic              r_vs_s2;
    logic              r_vs_s3;

    logic              w_vs_evt;
    logic [NUM_CH-1:0] w_raw;
    logic [CNT_W-1:0]  w_pcnt_nxt [NUM_CH];

    assign w_vs_evt = r_vs_s2 & ~r_vs_s3;

    // Every channel restarts its counters on the same event, so one shared
    // frame counter serves all of them.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             w_started;
        logic             w_ended;
        logic [CNT_W:0]   w_win_end;
        logic [CNT_W-1:0] w_period;

        assign w_period  = r_act[g][c_F_PERIOD];
        assign w_started = (r_fcnt >= r_act[g][c_F_START]);
        assign w_ended   = (r_act[g][c_F_END] != c_ZERO) && (r_fcnt >= r_act[g][c_F_END]);
        assign w_win_end = {1'b0, r_act[g][c_F_DELAY]} + {1'b0, r_act[g][c_F_WIDTH]};

        assign w_raw[g] = w_started && !w_ended
                       && (r_act[g][c_F_WIDTH] != c_ZERO)
                       && (r_pcnt[g] >= r_act[g][c_F_DELAY])
                       && ({1'b0, r_pcnt[g]} < w_win_end);

        // PERIOD of zero saturates instead of wrapping: one pulse per frame.
        always_comb begin
            w_pcnt_nxt[g] = r_pcnt[g];
            if (w_started) begin
                if (w_period == c_ZERO) begin
                    if (r_pcnt[g] != c_MAX)
                        w_pcnt_nxt[g] = r_pcnt[g] + c_ONE;
                end else if (r_pcnt[g] >= w_period - c_ONE) begin
                    w_pcnt_nxt[g] = c_ZERO;
                end else begin
                    w_pcnt_nxt[g] = r_pcnt[g] + c_ONE;
                end
            end
        end
    end

    always_ff @(posedge REF_CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_vs_s3 <= 1'b0;
            r_fcnt  <= '0;
            r_pend  <= '0;
            r_done  <= '0;
            r_level <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_pcnt[c]     <= '0;
                r_stg_ctrl[c] <= '0;
                r_act_ctrl[c] <= '0;
                for (int f = 0; f < c_NFIELD; f++) begin
                    r_stg[c][f] <= '0;
                    r_act[c][f] <= '0;
                end
            end
        end else begin
            r_vs_s1 <= bus.VSYNC;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;

            if (w_vs_evt)
                r_fcnt <= '0;
            else if (r_fcnt != c_MAX)
                r_fcnt <= r_fcnt + c_ONE;

            for (int c = 0; c < NUM_CH; c++) begin
                r_pcnt[c]  <= w_vs_evt ? c_ZERO : w_pcnt_nxt[c];
                r_level[c] <= r_act_ctrl[c][1] ? (w_raw[c] ^ r_act_ctrl[c][0]) : r_act_ctrl[c][0];
                r_done[c]  <= w_vs_evt & r_pend[c];
                // A commit landing on the frame-start cycle survives the clear.
                r_pend[c]  <= (r_pend[c] & ~w_vs_evt) | (bus.COMMIT & bus.COMMIT_MASK[c]);

                if (w_vs_evt && r_pend[c]) begin
                    r_act_ctrl[c] <= r_stg_ctrl[c];
                    for (int f = 0; f < c_NFIELD; f++)
                        r_act[c][f] <= r_stg[c][f];
                end

                if (bus.WR_EN && (int'(bus.WR_CH) == c)) begin
                    for (int f = 0; f < c_NFIELD; f++)
                        if (int'(bus.WR_ADDR) == f)
                            r_stg[c][f] <= bus.WR_DATA;
                    if (int'(bus.WR_ADDR) == c_F_CTRL)
                        r_stg_ctrl[c] <= bus.WR_DATA[1:0];
                end
            end
        end
    end

    assign bus.PENDING      = r_pend;
    assign bus.SETTING_DONE = r_done;
    assign bus.LEVEL_SEL    = r_level;

endmodule
`default_nettype wire
